// File: rtl/output_holder_if.sv
// Byte handshake bundle between the encryption block, the output holder and the off-chip reader.
// The holder side (master) drives the presented byte and its valid flag.
interface output_holder_if;
    logic [7:0] byte_in;
    logic       byte_in_pulse;
    logic       ack_in;
    logic [7:0] byte_out;
    logic       byte_valid_out;

    modport master (
        input  byte_in,
        input  byte_in_pulse,
        input  ack_in,
        output byte_out,
        output byte_valid_out
    );

    modport slave (
        output byte_in,
        output byte_in_pulse,
        output ack_in,
        input  byte_out,
        input  byte_valid_out
    );
endinterface

// File: rtl/output_holder.sv
// Small FIFO that buffers encrypted bytes and hands them one at a time to an
// off-chip reader over a 4-phase valid/ack handshake with a synchronized ack.
module output_holder #(
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  nrst,
    output_holder_if.master       bus,
    input  logic                  clear_overflow,
    output logic                  fifo_full_out,
    output logic                  overflow_out,
    output logic [CW-1:0]         fill_count_out,
    output logic [1:0]            output_holder_state_out
);

    localparam int DATA_W = 8;
    localparam int PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        O_IDLE    = 2'b00,
        O_PRESENT = 2'b01,
        O_RELEASE = 2'b10
    } state_t;

    state_t state;
    state_t state_next;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic              ack_s1;
    logic              ack_s2;

    logic full;
    logic pop;
    logic drop;
    logic do_write;
    logic valid_next;
    logic load;

    assign full     = (count == CW'(DEPTH));
    assign pop      = (state == O_IDLE) && (count != '0);
    // A full FIFO still accepts a push when the head leaves at the same edge.
    assign drop     = bus.byte_in_pulse && full && !pop;
    assign do_write = bus.byte_in_pulse && !drop;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            ack_s1 <= 1'b0;
            ack_s2 <= 1'b0;
        end else begin
            ack_s1 <= bus.ack_in;
            ack_s2 <= ack_s1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr] <= bus.byte_in;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_write, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // A dropped push outranks a simultaneous clear request.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            overflow_out <= 1'b0;
        end else if (drop) begin
            overflow_out <= 1'b1;
        end else if (clear_overflow) begin
            overflow_out <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= O_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            O_IDLE:    if (pop)     state_next = O_PRESENT;
            O_PRESENT: if (ack_s2)  state_next = O_RELEASE;
            O_RELEASE: if (!ack_s2) state_next = O_IDLE;
            default:                state_next = O_IDLE;
        endcase
    end

    always_comb begin
        valid_next = bus.byte_valid_out;
        load       = 1'b0;
        case (state)
            O_IDLE: begin
                if (pop) begin
                    valid_next = 1'b1;
                    load       = 1'b1;
                end
            end
            O_PRESENT: if (ack_s2) valid_next = 1'b0;
            O_RELEASE: valid_next = bus.byte_valid_out;
            default:   valid_next = 1'b0;
        endcase
    end

    // byte_out is only reloaded on a pop, so it holds through release and idle.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            bus.byte_out       <= '0;
            bus.byte_valid_out <= 1'b0;
        end else begin
            bus.byte_valid_out <= valid_next;
            if (load) begin
                bus.byte_out <= mem[rd_ptr];
            end
        end
    end

    assign fifo_full_out           = full;
    assign fill_count_out          = count;
    assign output_holder_state_out = state;

endmodule
